// File: rtl/agu_split_unit.sv
`default_nettype none
// ============================================================================
//  Module      : agu_split_unit
//  Description : Load/store address generation with bus-aligned requests,
//                optional splitting of word-crossing accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
module agu_split_unit #(
    parameter int DATA_BUS_BITS = 32,
    parameter int BUS_BYTES     = DATA_BUS_BITS / 8,
    parameter bit SPLIT_EN      = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_BUS_BITS-1:0]     reg1,
    input  logic [31:0]                  instruction,
    output logic                         req_valid,
    input  logic                         req_ready,
    output logic [DATA_BUS_BITS-1:0]     req_addr,
    output logic [BUS_BYTES-1:0]         req_be,
    output logic                         req_we,
    output logic                         req_part,
    output logic                         req_last,
    output logic [$clog2(BUS_BYTES)-1:0] req_shift,
    output logic                         exc_valid,
    output logic                         exc_misaligned,
    output logic [DATA_BUS_BITS-1:0]     exc_addr
);

    localparam int c_OFFW  = $clog2(BUS_BYTES);
    localparam int c_CNTW  = c_OFFW + 3;
    localparam int c_MASKW = 2 * BUS_BYTES;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FIRST  = 2'd1;
    localparam logic [1:0] c_SECOND = 2'd2;
    localparam logic [1:0] c_EXC    = 2'd3;

    localparam logic [6:0] c_OP_LOAD  = 7'b0000011;
    localparam logic [6:0] c_OP_STORE = 7'b0100011;

    logic [1:0]               r_state;
    logic [DATA_BUS_BITS-1:0] r_ea;
    logic [1:0]               r_lg;
    logic                     r_we;
    logic                     r_exc_mis;

    // ---------------- decode of the incoming instruction ----------------
    logic                     w_is_load;
    logic                     w_is_store;
    logic [11:0]              w_imm12;
    logic [DATA_BUS_BITS-1:0] w_ea;
    logic [1:0]               w_lg;
    logic                     w_illegal;
    logic                     w_in_cross;
    logic                     w_accept;
    logic                     w_unused_bits;

    assign w_is_load  = (instruction[6:0] == c_OP_LOAD);
    assign w_is_store = (instruction[6:0] == c_OP_STORE);
    assign w_imm12    = w_is_store ? {instruction[31:25], instruction[11:7]}
                                   : instruction[31:20];
    assign w_ea       = reg1 + {{(DATA_BUS_BITS-12){w_imm12[11]}}, w_imm12};
    assign w_lg       = instruction[13:12];
    // Doubleword accesses only exist on a 64-bit bus.
    assign w_illegal  = !(w_is_load || w_is_store) ||
                        ((w_lg == 2'd3) && (BUS_BYTES < 8));
    assign w_in_cross = ({{(c_CNTW-c_OFFW){1'b0}}, w_ea[c_OFFW-1:0]} +
                         (c_CNTW'(1) << w_lg)) > c_CNTW'(BUS_BYTES);
    assign w_accept   = in_valid && (r_state == c_IDLE);
    assign w_unused_bits = &{1'b0, instruction[19:14]};

    // ---------------- registered access geometry ----------------
    logic [c_OFFW-1:0]        w_off;
    logic [c_CNTW-1:0]        w_size;
    logic                     w_cross;
    logic [c_MASKW-1:0]       w_shifted;
    logic [DATA_BUS_BITS-1:0] w_base;

    assign w_off     = r_ea[c_OFFW-1:0];
    assign w_size    = c_CNTW'(1) << r_lg;
    assign w_cross   = ({{(c_CNTW-c_OFFW){1'b0}}, w_off} + w_size) > c_CNTW'(BUS_BYTES);
    assign w_shifted = (~({c_MASKW{1'b1}} << w_size)) << w_off;
    assign w_base    = {r_ea[DATA_BUS_BITS-1:c_OFFW], {c_OFFW{1'b0}}};

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_state   <= c_IDLE;
            r_ea      <= '0;
            r_lg      <= '0;
            r_we      <= 1'b0;
            r_exc_mis <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_ea <= w_ea;
                        r_lg <= w_lg;
                        r_we <= w_is_store;
                        if (w_illegal) begin
                            r_state   <= c_EXC;
                            r_exc_mis <= 1'b0;
                        end else if (w_in_cross && !SPLIT_EN) begin
                            r_state   <= c_EXC;
                            r_exc_mis <= 1'b1;
                        end else begin
                            r_state <= c_FIRST;
                        end
                    end
                end
                c_FIRST: begin
                    if (req_ready) r_state <= w_cross ? c_SECOND : c_IDLE;
                end
                c_SECOND: begin
                    if (req_ready) r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready       = (r_state == c_IDLE);
        req_valid      = 1'b0;
        req_addr       = '0;
        req_be         = '0;
        req_we         = 1'b0;
        req_part       = 1'b0;
        req_last       = 1'b0;
        req_shift      = '0;
        exc_valid      = 1'b0;
        exc_misaligned = 1'b0;
        exc_addr       = '0;
        case (r_state)
            c_FIRST: begin
                req_valid = 1'b1;
                req_addr  = w_base;
                req_be    = w_shifted[BUS_BYTES-1:0];
                req_we    = r_we;
                req_last  = !w_cross;
                req_shift = w_off;
            end
            c_SECOND: begin
                req_valid = 1'b1;
                req_addr  = w_base + DATA_BUS_BITS'(BUS_BYTES);
                req_be    = w_shifted[c_MASKW-1:BUS_BYTES];
                req_we    = r_we;
                req_part  = 1'b1;
                req_last  = 1'b1;
                req_shift = w_off;
            end
            c_EXC: begin
                exc_valid      = 1'b1;
                exc_misaligned = r_exc_mis;
                exc_addr       = r_exc_mis ? r_ea : '0;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_agu_split_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_agu_split_unit
//  Description : Directed self-checking bench for agu_split_unit (32-bit bus),
//                split and exception-only variants side by side.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_agu_split_unit;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_valid_ns, req_ready;
    logic [31:0] reg1, instruction;

    logic        in_ready, req_valid, req_we, req_part, req_last;
    logic [31:0] req_addr, exc_addr;
    logic [3:0]  req_be;
    logic [1:0]  req_shift;
    logic        exc_valid, exc_misaligned;

    logic        ns_in_ready, ns_req_valid, ns_req_we, ns_req_part, ns_req_last;
    logic [31:0] ns_req_addr, ns_exc_addr;
    logic [3:0]  ns_req_be;
    logic [1:0]  ns_req_shift;
    logic        ns_exc_valid, ns_exc_misaligned;

    int n_cmp = 0;
    int n_err = 0;

    // valid, addr, be, we, part, last, shift
    logic [41:0] w_obs;
    logic [41:0] exp_v;
    logic [33:0] w_exc;
    logic [33:0] w_ns_exc;
    assign w_obs    = {req_valid, req_addr, req_be, req_we, req_part, req_last, req_shift};
    assign w_exc    = {exc_valid, exc_misaligned, exc_addr};
    assign w_ns_exc = {ns_exc_valid, ns_exc_misaligned, ns_exc_addr};

    always #5 clk = ~clk;

    agu_split_unit #(.DATA_BUS_BITS(32), .BUS_BYTES(4), .SPLIT_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .reg1(reg1), .instruction(instruction), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_be(req_be), .req_we(req_we), .req_part(req_part),
        .req_last(req_last), .req_shift(req_shift), .exc_valid(exc_valid),
        .exc_misaligned(exc_misaligned), .exc_addr(exc_addr)
    );

    agu_split_unit #(.DATA_BUS_BITS(32), .BUS_BYTES(4), .SPLIT_EN(1'b0)) u_dut_ns (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid_ns), .in_ready(ns_in_ready),
        .reg1(reg1), .instruction(instruction), .req_valid(ns_req_valid), .req_ready(req_ready),
        .req_addr(ns_req_addr), .req_be(ns_req_be), .req_we(ns_req_we), .req_part(ns_req_part),
        .req_last(ns_req_last), .req_shift(ns_req_shift), .exc_valid(ns_exc_valid),
        .exc_misaligned(ns_exc_misaligned), .exc_addr(ns_exc_addr)
    );

    function automatic logic [31:0] mk_load(input logic [11:0] imm, input logic [2:0] f3);
        return {imm, 5'd1, f3, 5'd2, 7'b0000011};
    endfunction

    function automatic logic [31:0] mk_store(input logic [11:0] imm, input logic [2:0] f3);
        return {imm[11:5], 5'd3, 5'd1, f3, imm[4:0], 7'b0100011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction to the split unit for a single cycle.
    task automatic issue(input logic [31:0] r, input logic [31:0] ins);
        reg1 = r; instruction = ins; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_valid_ns = 1'b0; req_ready = 1'b0;
        reg1 = '0; instruction = '0;
        tick(); tick();
        reset = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++;
        if (w_obs !== 42'd0) begin n_err++; $display("FAIL reset_req got %h want 0", w_obs); end
        n_cmp++;
        if (w_exc !== 34'd0) begin n_err++; $display("FAIL reset_exc got %h want 0", w_exc); end
    endtask

    task automatic test_aligned_load();
        issue(32'h1000, mk_load(12'd4, 3'b010));
        exp_v = {1'b1, 32'h0000_1004, 4'b1111, 1'b0, 1'b0, 1'b1, 2'd0};
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL lw_req got %h want %h", w_obs, exp_v); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_err++; $display("FAIL lw_busy got %b want 0", in_ready); end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        n_cmp++;
        if ({req_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL lw_done got %b want 01", {req_valid, in_ready});
        end
    endtask

    task automatic test_split_half();
        issue(32'h1001, mk_load(12'd2, 3'b001));
        exp_v = {1'b1, 32'h0000_1000, 4'b1000, 1'b0, 1'b0, 1'b0, 2'd3};
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL lh_part0 got %h want %h", w_obs, exp_v); end
        req_ready = 1'b1;
        tick();
        exp_v = {1'b1, 32'h0000_1004, 4'b0001, 1'b0, 1'b1, 1'b1, 2'd3};
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL lh_part1 got %h want %h", w_obs, exp_v); end
        tick();
        req_ready = 1'b0;
        n_cmp++;
        if ({req_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL lh_done got %b want 01", {req_valid, in_ready});
        end
    endtask

    task automatic test_neg_store();
        issue(32'h2000, mk_store(12'hFFC, 3'b010));
        exp_v = {1'b1, 32'h0000_1FFC, 4'b1111, 1'b1, 1'b0, 1'b1, 2'd0};
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL sw_neg got %h want %h", w_obs, exp_v); end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
    endtask

    task automatic test_wrap();
        issue(32'hFFFF_FFFE, mk_load(12'd0, 3'b010));
        exp_v = {1'b1, 32'hFFFF_FFFC, 4'b1100, 1'b0, 1'b0, 1'b0, 2'd2};
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL wrap_part0 got %h want %h", w_obs, exp_v); end
        req_ready = 1'b1;
        tick();
        exp_v = {1'b1, 32'h0000_0000, 4'b0011, 1'b0, 1'b1, 1'b1, 2'd2};
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL wrap_part1 got %h want %h", w_obs, exp_v); end
        tick();
        req_ready = 1'b0;
    endtask

    task automatic test_no_split();
        reg1 = 32'hFFFF_FFFE; instruction = mk_load(12'd0, 3'b010); in_valid_ns = 1'b1;
        n_cmp++;
        if (ns_in_ready !== 1'b1) begin n_err++; $display("FAIL ns_idle got %b want 1", ns_in_ready); end
        tick();
        in_valid_ns = 1'b0;
        n_cmp++;
        if (w_ns_exc !== {1'b1, 1'b1, 32'hFFFF_FFFE}) begin
            n_err++; $display("FAIL ns_exc got %h want %h", w_ns_exc, {1'b1, 1'b1, 32'hFFFF_FFFE});
        end
        n_cmp++;
        if (ns_req_valid !== 1'b0) begin n_err++; $display("FAIL ns_req_exc got %b want 0", ns_req_valid); end
        tick();
        n_cmp++;
        if ({ns_exc_valid, ns_req_valid, ns_in_ready} !== 3'b001) begin
            n_err++; $display("FAIL ns_after got %b want 001", {ns_exc_valid, ns_req_valid, ns_in_ready});
        end
    endtask

    task automatic test_backpressure_flush();
        issue(32'h3002, mk_load(12'd0, 3'b010));
        exp_v = {1'b1, 32'h0000_3000, 4'b1100, 1'b0, 1'b0, 1'b0, 2'd2};
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (w_obs !== exp_v) begin
                n_err++; $display("FAIL bp_hold%0d got %h want %h", i, w_obs, exp_v);
            end
            tick();
        end
        req_ready = 1'b1;
        tick();
        req_ready = 1'b0;
        exp_v = {1'b1, 32'h0000_3004, 4'b0011, 1'b0, 1'b1, 1'b1, 2'd2};
        n_cmp++;
        if (w_obs !== exp_v) begin n_err++; $display("FAIL bp_part1 got %h want %h", w_obs, exp_v); end
        flush = 1'b1; req_ready = 1'b1;
        tick();
        flush = 1'b0; req_ready = 1'b0;
        n_cmp++;
        if ({req_valid, in_ready, exc_valid} !== 3'b010) begin
            n_err++; $display("FAIL flush got %b want 010", {req_valid, in_ready, exc_valid});
        end
    endtask

    task automatic test_illegal();
        issue(32'h1234, 32'h0020_8033);
        n_cmp++;
        if (w_exc !== {1'b1, 1'b0, 32'd0}) begin
            n_err++; $display("FAIL illegal_op got %h want %h", w_exc, {1'b1, 1'b0, 32'd0});
        end
        n_cmp++;
        if (req_valid !== 1'b0) begin n_err++; $display("FAIL illegal_req got %b want 0", req_valid); end
        tick();
        n_cmp++;
        if ({exc_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL illegal_pulse got %b want 01", {exc_valid, in_ready});
        end
        // Doubleword on a 32-bit bus is illegal.
        issue(32'h1000, mk_load(12'd0, 3'b011));
        n_cmp++;
        if (w_exc !== {1'b1, 1'b0, 32'd0}) begin
            n_err++; $display("FAIL illegal_ld got %h want %h", w_exc, {1'b1, 1'b0, 32'd0});
        end
        tick();
    endtask

    task automatic test_byte_offsets();
        for (int k = 0; k < 4; k++) begin
            issue(32'h4000 + k, mk_load(12'd0, 3'b000));
            exp_v = {1'b1, 32'h0000_4000, 4'(1 << k), 1'b0, 1'b0, 1'b1, 2'(k)};
            n_cmp++;
            if (w_obs !== exp_v || exc_valid !== 1'b0) begin
                n_err++; $display("FAIL lb_off%0d got %h want %h", k, w_obs, exp_v);
            end
            req_ready = 1'b1;
            tick();
            req_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        reg1 = 32'h5000; instruction = mk_load(12'd0, 3'b010);
        in_valid = 1'b1; req_ready = 1'b1;
        tick();
        n_cmp++;
        if (req_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first got %b want 1", req_valid); end
        tick();
        n_cmp++;
        if ({req_valid, in_ready} !== 2'b01) begin
            n_err++; $display("FAIL b2b_gap got %b want 01", {req_valid, in_ready});
        end
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if ({req_valid, req_addr} !== {1'b1, 32'h0000_5000}) begin
            n_err++; $display("FAIL b2b_second got %h want %h", {req_valid, req_addr}, {1'b1, 32'h0000_5000});
        end
        tick();
        req_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_aligned_load();
        test_split_half();
        test_neg_store();
        test_wrap();
        test_no_split();
        test_backpressure_flush();
        test_illegal();
        test_byte_offsets();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/agu_split_unit.md
Name: agu_split_unit

Overview:
- Sequential, parametrised load/store address generation unit for the core's memory stage.
- Per accepted instruction:
  - decodes RISC-V load (I-type) or store (S-type) immediates;
  - computes the effective address reg1 + sext(imm);
  - issues bus-aligned requests with byte enables.
- Misaligned accesses that cross a bus word are either split into two aligned transactions or flagged as a misalignment exception, selected by parameter.

Parameters:
- DataBusBits, 32, datapath/address width (32 or 64).
- BUS_BYTES, DataBusBits/8, bytes per bus word; power of two.
- SPLIT_EN, 1, 1 = split boundary-crossing accesses; 0 = raise exc_misaligned.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous abort of any in-flight operation.
- in_valid  in  1  instruction/operand valid.
- in_ready  out  1  unit can accept (state IDLE).
- reg1  in  DataBusBits  base register value.
- instruction  in  32  raw instruction word.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts request.
- req_addr  out  DataBusBits  aligned address (low log2(BUS_BYTES) bits zero).
- req_be  out  BUS_BYTES  byte enables.
- req_we  out  1  1 = store.
- req_part  out  1  0 = first/only part, 1 = second part.
- req_last  out  1  final part of this access.
- req_shift  out  log2(BUS_BYTES)  byte offset of EA, for data alignment downstream.
- exc_valid  out  1  one-cycle exception pulse.
- exc_misaligned  out  1  cause: misaligned (else illegal).
- exc_addr  out  DataBusBits  faulting EA (0 for illegal).

Behaviour:
- Reset or flush:
  - state = IDLE; in_ready = 1.
  - req_valid, req_addr, req_be, req_we, req_part, req_last, req_shift, exc_valid, exc_misaligned, exc_addr all = 0.
  - Reset or flush mid-operation drops any pending part without completing it.
  - flush has priority over every handshake in the same cycle.
- Decode, combinational on instruction:
  - opcode 0000011 = load, imm = instr[31:20].
  - opcode 0100011 = store, imm = {instr[31:25], instr[11:7]}.
  - imm is sign-extended to DataBusBits.
  - size = 1 << funct3[1:0].
  - size 8 when BUS_BYTES = 4 is illegal; any other opcode is illegal.
- EA = reg1 + sext(imm), modulo 2^DataBusBits; the carry is discarded.
- Accept happens when in_valid & in_ready. At accept, EA, size and we are registered.
- Latency: request or exception is visible the cycle after accept.
- States: IDLE, FIRST, SECOND, EXC.
- IDLE:
  - on accept → EXC if illegal, or if misaligned-crossing with SPLIT_EN = 0;
  - otherwise → FIRST.
- EXC:
  - exc_valid = 1 for one cycle; exc_misaligned and exc_addr set accordingly;
  - → IDLE.
- Exceptions use the EXC state only; no request is issued.
- FIRST:
  - req_valid = 1; req_addr = EA & ~(BUS_BYTES-1); req_shift = EA[log2B-1:0].
  - req_be = (((1 << size) - 1) << offset), truncated to BUS_BYTES bits.
  - cross = offset + size > BUS_BYTES; req_last = !cross.
  - On req_ready: → SECOND if cross, else → IDLE.
- SECOND:
  - req_addr = FIRST addr + BUS_BYTES, wrapping modulo 2^DataBusBits.
  - req_be = upper BUS_BYTES bits of the 2*BUS_BYTES-wide shifted mask.
  - req_part = 1; req_last = 1.
  - On req_ready → IDLE.
- Request outputs hold stable while req_valid & !req_ready.
- Aligned, non-crossing accesses (including misaligned-within-word, e.g. a byte at any offset) never raise an exception.
- in_ready = 0 in FIRST, SECOND and EXC. No back-to-back accept in the final-handshake cycle: one idle cycle between accesses.
- req_we is constant across both parts of an access.

Test Plan (DataBusBits = 32):
- Aligned word load: reg1 = 0x1000, lw imm = 4 → next cycle req_addr = 0x1004, be = 1111, part = 0, last = 1, shift = 0, we = 0.
- Split half: reg1 = 0x1001, lh imm = 2 (EA 0x1003), SPLIT_EN = 1 →
  - part 0: addr 0x1000, be = 1000, last = 0;
  - part 1: addr 0x1004, be = 0001, last = 1.
- Negative store immediate: reg1 = 0x2000, sw imm = -4 → addr 0x1FFC, be = 1111, we = 1.
- Wrap: reg1 = 0xFFFFFFFE, lw imm = 0 →
  - part 0: addr 0xFFFFFFFC, be = 1100;
  - part 1: addr 0x00000000, be = 0011.
- SPLIT_EN = 0, same wrap case → exc_valid one cycle, exc_misaligned = 1, exc_addr = 0xFFFFFFFE, req_valid never asserted.
- Backpressure and flush:
  - hold req_ready = 0 for 3 cycles in FIRST → outputs stable throughout;
  - assert flush in SECOND → next cycle req_valid = 0, in_ready = 1;
  - opcode 0110011 → exc_valid with exc_misaligned = 0.
